// File: rtl/orient_centroid.sv
// rtl/orient_centroid.sv - sliding (2R+1)^2 intensity-centroid orientation, signed cos/sin out
// Optional circular pixel mask selected by defining ORIENT_CIRCLE_MASK_EN.
module orient_centroid #(
  parameter int PATCH_R  = 3,
  parameter int PIX_W    = 8,
  parameter int OUT_FRAC = 10
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [(2*PATCH_R+1)*PIX_W-1:0] i_col,
  input  logic                           i_valid,
  input  logic                           i_sol,
  output logic                           o_valid,
  output logic signed [OUT_FRAC+1:0]     o_cos,
  output logic signed [OUT_FRAC+1:0]     o_sin
);
  localparam int N     = 2*PATCH_R + 1;
  localparam int COL_W = N*PIX_W;
  localparam int MOM_W = PIX_W + $clog2(N*PATCH_R*(PATCH_R+1)) + 1;
  localparam int SQ_W  = 2*MOM_W;
  localparam int RT_W  = MOM_W + 1;
  localparam int SS_W  = 2*RT_W;
  localparam int DV_W  = MOM_W + OUT_FRAC;
  localparam int Q_W   = OUT_FRAC + 1;
  localparam int O_W   = OUT_FRAC + 2;
  localparam int CNT_W = $clog2(N+1);
  localparam int SD_W  = 2*MOM_W + 3;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(N);
  localparam logic [DV_W-1:0]  ONE_DV = DV_W'(1) << OUT_FRAC;
  localparam logic [Q_W-1:0]   ONE_Q  = Q_W'(1) << OUT_FRAC;

  // Only N-1 columns are stored; the incoming column completes the window.
  logic [COL_W-1:0] win_q [N-1];
  logic [COL_W-1:0] win_d [N];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emit;

  always_comb begin
    for (int j = 0; j < N-1; j++) win_d[j] = win_q[j];
    win_d[N-1] = i_col;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_valid) begin
      if (i_sol) cnt_d = CNT_W'(1);
      else if (cnt_q != FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (i_sol) begin
      cnt_d = '0;
    end
    emit = i_valid && (cnt_d == FULL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N-1; i++) win_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (i_valid) for (int i = 0; i < N-1; i++) win_q[i] <= win_d[i+1];
    end
  end

  // Per-column sum S and y-weighted sum W, then x-weighted over columns.
  logic signed [MOM_W-1:0] col_s, col_w, pix_s, x_s, y_s, m10_d, m01_d;
  logic                    keep;

  always_comb begin
    m10_d = '0; m01_d = '0; col_s = '0; col_w = '0;
    pix_s = '0; x_s = '0; y_s = '0; keep = 1'b0;
    for (int j = 0; j < N; j++) begin
      col_s = '0;
      col_w = '0;
      x_s   = MOM_W'(j - PATCH_R);
      for (int k = 0; k < N; k++) begin
        y_s = MOM_W'(k - PATCH_R);
`ifdef ORIENT_CIRCLE_MASK_EN
        keep = ((j-PATCH_R)*(j-PATCH_R) + (k-PATCH_R)*(k-PATCH_R)) <= PATCH_R*PATCH_R;
`else
        keep = 1'b1;
`endif
        pix_s = keep ? MOM_W'(win_d[j][k*PIX_W +: PIX_W]) : '0;
        col_s = col_s + pix_s;
        col_w = col_w + y_s * pix_s;
      end
      m10_d = m10_d + x_s * col_s;
      m01_d = m01_d + col_w;
    end
  end

  function automatic logic [RT_W-1:0] isqrt(input logic [SS_W-1:0] v);
    logic [SS_W-1:0] rem, trial;
    logic [RT_W-1:0] root;
    rem = '0; trial = '0; root = '0;
    for (int i = RT_W-1; i >= 0; i--) begin
      rem   = {rem[SS_W-3:0], v[2*i+1 -: 2]};
      trial = {{(SS_W-RT_W-2){1'b0}}, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[RT_W-2:0], 1'b1};
      end else begin
        root = {root[RT_W-2:0], 1'b0};
      end
    end
    return root;
  endfunction

  logic                    v1, v2, v3, v4, v5, v6;
  logic signed [MOM_W-1:0] m10_1, m01_1;
  logic [SD_W-1:0]         sd2, sd3, sd4, sd5;
  logic [SQ_W-1:0]         sq10_3, sq01_3;
  logic [SS_W-1:0]         ss_4;
  logic [RT_W-1:0]         rt_5;
  logic [Q_W-1:0]          q10_6, q01_6;
  logic                    n10_6, n01_6;
  logic [MOM_W-1:0]        a10_5, a01_5;
  logic                    n10_5, n01_5, z_5;
  logic [RT_W-1:0]         dvs;
  logic [DV_W-1:0]         q10_f, q01_f;

  // Sideband layout: {|m10|, |m01|, m10<0, m01<0, both zero}
  assign {a10_5, a01_5, n10_5, n01_5, z_5} = sd5;

  always_comb begin
    dvs   = (rt_5 == '0) ? RT_W'(1) : rt_5;
    q10_f = (DV_W'(a10_5) << OUT_FRAC) / DV_W'(dvs);
    q01_f = (DV_W'(a01_5) << OUT_FRAC) / DV_W'(dvs);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {v1, v2, v3, v4, v5, v6} <= '0;
      m10_1 <= '0; m01_1 <= '0;
      sd2 <= '0; sd3 <= '0; sd4 <= '0; sd5 <= '0;
      sq10_3 <= '0; sq01_3 <= '0; ss_4 <= '0; rt_5 <= '0;
      q10_6 <= '0; q01_6 <= '0; n10_6 <= 1'b0; n01_6 <= 1'b0;
      o_valid <= 1'b0; o_cos <= '0; o_sin <= '0;
    end else begin
      v1 <= emit;  v2 <= v1;  v3 <= v2;  v4 <= v3;  v5 <= v4;  v6 <= v5;
      o_valid <= v6;
      m10_1 <= m10_d;
      m01_1 <= m01_d;
      sd2 <= {m10_1[MOM_W-1] ? MOM_W'(-m10_1) : MOM_W'(m10_1),
              m01_1[MOM_W-1] ? MOM_W'(-m01_1) : MOM_W'(m01_1),
              m10_1[MOM_W-1], m01_1[MOM_W-1],
              (m10_1 == '0) && (m01_1 == '0)};
      sq10_3 <= SQ_W'(sd2[SD_W-1 -: MOM_W]) * SQ_W'(sd2[SD_W-1 -: MOM_W]);
      sq01_3 <= SQ_W'(sd2[SD_W-MOM_W-1 -: MOM_W]) * SQ_W'(sd2[SD_W-MOM_W-1 -: MOM_W]);
      sd3    <= sd2;
      ss_4   <= SS_W'(sq10_3) + SS_W'(sq01_3);
      sd4    <= sd3;
      rt_5   <= isqrt(ss_4);
      sd5    <= sd4;
      q10_6  <= z_5 ? ONE_Q : (q10_f > ONE_DV) ? ONE_Q : Q_W'(q10_f);
      q01_6  <= z_5 ? '0    : (q01_f > ONE_DV) ? ONE_Q : Q_W'(q01_f);
      n10_6  <= n10_5;
      n01_6  <= n01_5;
      if (v6) begin
        o_cos <= n10_6 ? -O_W'(q10_6) : O_W'(q10_6);
        o_sin <= n01_6 ? -O_W'(q01_6) : O_W'(q01_6);
      end
    end
  end
endmodule

// File: tb/tb_orient_centroid.sv
// tb/tb_orient_centroid.sv - directed + randomized bench for orient_centroid
// Reference computes moments, sqrt and ratios with plain integer arithmetic on a column queue.
`timescale 1ns/1ps
module tb_orient_centroid;
  localparam int R   = 3;
  localparam int N   = 2*R + 1;
  localparam int PW  = 8;
  localparam int F   = 10;
  localparam int OW  = F + 2;
  localparam int CW  = N*PW;
  localparam int LAT = 7;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid = 1'b0;
  logic                 sol = 1'b0;
  logic [CW-1:0]        col = '0;
  logic                 o_valid;
  logic signed [OW-1:0] o_cos, o_sin;

  int vectors = 0;
  int miscompares = 0;

  logic [CW-1:0] mwin[$];
  int            mcnt = 0;
  bit            pv [LAT];
  logic [OW-1:0] pc [LAT];
  logic [OW-1:0] ps [LAT];
  logic [OW-1:0] held_c = '0;
  logic [OW-1:0] held_s = '0;

  always #5 clk = ~clk;

  orient_centroid #(.PATCH_R(R), .PIX_W(PW), .OUT_FRAC(F)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_col(col), .i_valid(valid), .i_sol(sol),
    .o_valid(o_valid), .o_cos(o_cos), .o_sin(o_sin)
  );

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(int x, int y);
`ifdef ORIENT_CIRCLE_MASK_EN
    return (x*x + y*y) <= R*R;
`else
    return (x*x + y*y) <= 2*R*R;
`endif
  endfunction

  function automatic longint isqrt_ref(longint v);
    longint r;
    r = longint'($sqrt(real'(v)));
    while (r*r > v) r--;
    while ((r+1)*(r+1) <= v) r++;
    return r;
  endfunction

  function automatic logic [OW-1:0] ratio(longint m, longint rt);
    longint q;
    q = ((m < 0) ? -m : m) * (longint'(1) << F) / rt;
    if (q > (longint'(1) << F)) q = longint'(1) << F;
    return OW'((m < 0) ? -q : q);
  endfunction

  task automatic model_window(output logic [OW-1:0] c, output logic [OW-1:0] s);
    longint m10, m01, rt;
    logic [CW-1:0] cv;
    int p;
    m10 = 0; m01 = 0;
    for (int j = 0; j < N; j++) begin
      cv = mwin[j];
      for (int k = 0; k < N; k++) begin
        p = int'(cv[k*PW +: PW]);
        if (in_win(j-R, k-R)) begin
          m10 += longint'(j-R) * p;
          m01 += longint'(k-R) * p;
        end
      end
    end
    if (m10 == 0 && m01 == 0) begin
      c = OW'(1 << F);
      s = '0;
    end else begin
      rt = isqrt_ref(m10*m10 + m01*m01);
      c = ratio(m10, rt);
      s = ratio(m01, rt);
    end
  endtask

  task automatic step(input logic [CW-1:0] c_in, input bit v, input bit s_in);
    bit ev;
    logic [OW-1:0] ec, es;
    ev = 1'b0; ec = '0; es = '0;
    @(negedge clk);
    col = c_in; valid = v; sol = s_in;
    if (v) begin
      mwin.push_back(c_in);
      if (mwin.size() > N) void'(mwin.pop_front());
      mcnt = s_in ? 1 : ((mcnt < N) ? mcnt + 1 : N);
      if (mcnt == N) begin
        ev = 1'b1;
        model_window(ec, es);
      end
    end else if (s_in) begin
      mcnt = 0;
    end
    for (int i = LAT-1; i > 0; i--) begin
      pv[i] = pv[i-1]; pc[i] = pc[i-1]; ps[i] = ps[i-1];
    end
    pv[0] = ev; pc[0] = ec; ps[0] = es;
    @(posedge clk);
    #1;
    if (pv[LAT-1]) begin
      held_c = pc[LAT-1];
      held_s = ps[LAT-1];
    end
    chk("o_valid", OW'(o_valid), OW'(pv[LAT-1]));
    chk("o_cos", o_cos, held_c);
    chk("o_sin", o_sin, held_s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; sol = 1'b0;
    mwin.delete();
    mcnt = 0; held_c = '0; held_s = '0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pc[i] = '0; ps[i] = '0; end
    @(posedge clk);
    #1;
    chk("rst_valid", OW'(o_valid), '0);
    chk("rst_cos", o_cos, '0);
    chk("rst_sin", o_sin, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [CW-1:0] fill(int v);
    logic [CW-1:0] c;
    for (int k = 0; k < N; k++) c[k*PW +: PW] = PW'(v);
    return c;
  endfunction

  function automatic logic [CW-1:0] onepix(int k, int v);
    logic [CW-1:0] c;
    c = '0;
    c[k*PW +: PW] = PW'(v);
    return c;
  endfunction

  function automatic logic [CW-1:0] rnd_col();
    return CW'({$urandom(), $urandom()});
  endfunction

  initial begin
    do_reset();
    // Uniform patch
    repeat (N) step(fill(100), 1'b1, 1'b0);
    repeat (LAT) step('0, 1'b0, 1'b0);
    // Newest column only
    repeat (N-1) step('0, 1'b1, 1'b0);
    step(fill(255), 1'b1, 1'b0);
    repeat (LAT) step('0, 1'b0, 1'b0);
    // Top row only
    repeat (N) step(onepix(0, 255), 1'b1, 1'b0);
    repeat (LAT) step('0, 1'b0, 1'b0);
    // Single pixel at (+1,+1)
    repeat (R+1) step('0, 1'b1, 1'b0);
    step(onepix(R+1, 200), 1'b1, 1'b0);
    repeat (R-1) step('0, 1'b1, 1'b0);
    repeat (LAT) step('0, 1'b0, 1'b0);
    // Corner pixel (+3,+3), excluded by the circular mask
    repeat (N-1) step('0, 1'b1, 1'b0);
    step(onepix(N-1, 255), 1'b1, 1'b0);
    repeat (LAT) step('0, 1'b0, 1'b0);
    // Framing: restart on the 4th column, then a lone i_sol
    step(rnd_col(), 1'b1, 1'b1);
    repeat (2) step(rnd_col(), 1'b1, 1'b0);
    step(rnd_col(), 1'b1, 1'b1);
    repeat (N-1) step(rnd_col(), 1'b1, 1'b0);
    step('0, 1'b0, 1'b1);
    repeat (N-1) step(rnd_col(), 1'b1, 1'b0);
    step(rnd_col(), 1'b1, 1'b0);
    // Reset with results in flight
    repeat (3) step(rnd_col(), 1'b1, 1'b0);
    do_reset();
    repeat (LAT+2) step('0, 1'b0, 1'b0);
    repeat (N) step(rnd_col(), 1'b1, 1'b0);
    // Random gaps and occasional start-of-line
    for (int t = 0; t < 300; t++)
      step(rnd_col(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
    // Sparse random patches exercise small and zero moments
    for (int t = 0; t < 120; t++)
      step(onepix($urandom_range(0, N-1), $urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'b0);
    repeat (LAT+1) step('0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
